// File: rtl/mips_def_pkg.sv
// Shared MIPS definitions: opcode and function-field constants, the encoder
// mnemonic enumeration and the encoder FSM state type.
package mips_def;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction bits [5:0])
    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_SRA  = 6'h03;
    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_SUBU = 6'h23;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_XOR  = 6'h26;
    localparam logic [5:0] FUNC_NOR  = 6'h27;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;
    localparam logic [5:0] FUNC_SLTU = 6'h2B;

    // Mnemonics accepted by the encoder. Codes 28..31 are unused and are
    // treated as illegal, exactly like INS_NONE.
    typedef enum logic [4:0] {
        INS_NONE  = 5'd0,
        INS_ADD, INS_ADDU, INS_SUB, INS_SUBU, INS_AND, INS_OR, INS_XOR,
        INS_NOR, INS_SLT, INS_SLTU, INS_SLL, INS_SRL, INS_SRA, INS_JR,
        INS_ADDI, INS_ADDIU, INS_ORI, INS_XORI, INS_LUI, INS_LW, INS_SW,
        INS_BEQ, INS_BNE, INS_SLTI, INS_SLTIU,
        INS_J, INS_JAL
    } ins_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } enc_state_t;

endpackage

// File: rtl/ins_pack.sv
// ins_pack: combinational packing of one instruction descriptor into a
// 32-bit MIPS word.
//   op                         mnemonic
//   rs, rt, rd, shamt          register / shift fields
//   imm                        16-bit immediate
//   addr                       26-bit jump target
//   word                       encoded instruction (0 when illegal)
//   illegal                    op is INS_NONE or outside the enumeration
module ins_pack
    import mips_def::*;
(
    input  ins_op_t     op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    output logic [31:0] word,
    output logic        illegal
);

    logic [5:0] opc;
    logic [5:0] func;
    logic       is_r;
    logic       is_i;
    logic       is_j;
    logic       is_shift;
    logic       is_jr;

    always_comb begin
        opc     = 6'h00;
        func    = 6'h00;
        is_r    = 1'b0;
        is_i    = 1'b0;
        is_j    = 1'b0;
        illegal = 1'b0;
        case (op)
            INS_ADD:   begin is_r = 1'b1; func = FUNC_ADD;  end
            INS_ADDU:  begin is_r = 1'b1; func = FUNC_ADDU; end
            INS_SUB:   begin is_r = 1'b1; func = FUNC_SUB;  end
            INS_SUBU:  begin is_r = 1'b1; func = FUNC_SUBU; end
            INS_AND:   begin is_r = 1'b1; func = FUNC_AND;  end
            INS_OR:    begin is_r = 1'b1; func = FUNC_OR;   end
            INS_XOR:   begin is_r = 1'b1; func = FUNC_XOR;  end
            INS_NOR:   begin is_r = 1'b1; func = FUNC_NOR;  end
            INS_SLT:   begin is_r = 1'b1; func = FUNC_SLT;  end
            INS_SLTU:  begin is_r = 1'b1; func = FUNC_SLTU; end
            INS_SLL:   begin is_r = 1'b1; func = FUNC_SLL;  end
            INS_SRL:   begin is_r = 1'b1; func = FUNC_SRL;  end
            INS_SRA:   begin is_r = 1'b1; func = FUNC_SRA;  end
            INS_JR:    begin is_r = 1'b1; func = FUNC_JR;   end
            INS_ADDI:  begin is_i = 1'b1; opc = OP_ADDI;    end
            INS_ADDIU: begin is_i = 1'b1; opc = OP_ADDIU;   end
            INS_ORI:   begin is_i = 1'b1; opc = OP_ORI;     end
            INS_XORI:  begin is_i = 1'b1; opc = OP_XORI;    end
            INS_LUI:   begin is_i = 1'b1; opc = OP_LUI;     end
            INS_LW:    begin is_i = 1'b1; opc = OP_LW;      end
            INS_SW:    begin is_i = 1'b1; opc = OP_SW;      end
            INS_BEQ:   begin is_i = 1'b1; opc = OP_BEQ;     end
            INS_BNE:   begin is_i = 1'b1; opc = OP_BNE;     end
            INS_SLTI:  begin is_i = 1'b1; opc = OP_SLTI;    end
            INS_SLTIU: begin is_i = 1'b1; opc = OP_SLTIU;   end
            INS_J:     begin is_j = 1'b1; opc = OP_J;       end
            INS_JAL:   begin is_j = 1'b1; opc = OP_JAL;     end
            default:   illegal = 1'b1;
        endcase
    end

    // Shifts take their operand from rt and the amount from shamt, so rs is
    // meaningless; JR only uses rs.
    assign is_shift = (op == INS_SLL) || (op == INS_SRL) || (op == INS_SRA);
    assign is_jr    = (op == INS_JR);

    always_comb begin
        word = 32'h0;
        if (is_r) begin
            word = {OP_RTYPE,
                    is_shift ? 5'd0 : rs,
                    is_jr    ? 5'd0 : rt,
                    is_jr    ? 5'd0 : rd,
                    is_shift ? shamt : 5'd0,
                    func};
        end else if (is_i) begin
            word = {opc, (op == INS_LUI) ? 5'd0 : rs, rt, imm};
        end else if (is_j) begin
            word = {opc, addr};
        end
    end

endmodule

// File: rtl/ins_encoder.sv
// ins_encoder: streams instruction descriptors into encoded words written to
// consecutive word addresses starting at base_addr.
//   clk, rst                  clock, asynchronous active-high reset
//   start, base_addr          begin a load (IDLE only) at base_addr & ~3
//   in_valid/in_ready, in_*   descriptor input; in_last ends the load
//   mem_wr/mem_ready          write output; consumed when both are high
//   mem_addr, mem_wdata       write address / encoded word
//   count                     words written in this load (saturates at DEPTH)
//   done                      one-cycle pulse when the load completes
//   err, ovf                  sticky illegal-op / overflow flags
//   dbg_state                 current FSM state (enc_state_t encoding)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; ready may depend on the consumer's ready, never on valid.
module ins_encoder
    import mips_def::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [31:0]                  base_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  ins_op_t                      in_op,
    input  logic [4:0]                   in_rs,
    input  logic [4:0]                   in_rt,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_shamt,
    input  logic [15:0]                  in_imm,
    input  logic [25:0]                  in_addr,
    input  logic                         in_last,
    output logic                         mem_wr,
    input  logic                         mem_ready,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done,
    output logic                         err,
    output logic                         ovf,
    output logic [1:0]                   dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    enc_state_t  state;
    enc_state_t  state_nx;
    logic [31:0] ptr;
    logic [31:0] word;
    logic        illegal;
    logic        accept;
    logic        full;
    logic        unused_base_bits;

    // Byte-offset bits of the base address are don't-care.
    assign unused_base_bits = ^base_addr[1:0];

    ins_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .addr    (in_addr),
        .word    (word),
        .illegal (illegal)
    );

    // The output register frees up on the same edge it is consumed, so a new
    // descriptor can be taken every cycle while mem_ready stays high.
    assign in_ready  = (state == ST_RUN) && (!mem_wr || mem_ready);
    assign accept    = in_valid && in_ready;
    assign full      = (count == CW'(DEPTH));
    assign done      = (state == ST_FIN);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (accept && in_last) state_nx = ST_DRAIN;
            // Leave once the last word is gone or is consumed on this edge.
            ST_DRAIN: if (!mem_wr || mem_ready) state_nx = ST_FIN;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_wr    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            ptr       <= 32'h0;
            count     <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                ptr   <= {base_addr[31:2], 2'b00};
                count <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
            end
            if (mem_wr && mem_ready) begin
                mem_wr <= 1'b0;
            end
            // Illegal and overflowing descriptors are consumed but dropped.
            if (accept) begin
                if (illegal) err <= 1'b1;
                if (full)    ovf <= 1'b1;
                if (!illegal && !full) begin
                    mem_wr    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= word;
                    ptr       <= ptr + 32'd4;
                    count     <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ins_encoder.sv
module tb_ins_encoder;
    import mips_def::*;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        in_valid_a, in_valid_b;
    logic        in_ready_a, in_ready_b;
    logic [31:0] base_addr;
    ins_op_t     in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_addr;
    logic        in_last;
    logic        mem_ready;
    logic        mem_wr_a, mem_wr_b;
    logic [31:0] mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
    logic [10:0] count_a;
    logic [1:0]  count_b;
    logic        done_a, done_b, err_a, err_b, ovf_a, ovf_b;
    logic [1:0]  st_a, st_b;

    logic        use_b;
    int          checks;
    int          passes;
    int          done_cnt_a, done_cnt_b;
    logic [31:0] cap_addr_a[$], cap_data_a[$], cap_addr_b[$], cap_data_b[$];

    ins_encoder u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_addr(in_addr), .in_last(in_last),
        .mem_wr(mem_wr_a), .mem_ready(mem_ready), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .count(count_a), .done(done_a),
        .err(err_a), .ovf(ovf_a), .dbg_state(st_a)
    );

    ins_encoder #(.DEPTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_addr(in_addr), .in_last(in_last),
        .mem_wr(mem_wr_b), .mem_ready(mem_ready), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .count(count_b), .done(done_b),
        .err(err_b), .ovf(ovf_b), .dbg_state(st_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write and done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_a && mem_ready) begin
                cap_addr_a.push_back(mem_addr_a);
                cap_data_a.push_back(mem_wdata_a);
            end
            if (mem_wr_b && mem_ready) begin
                cap_addr_b.push_back(mem_addr_b);
                cap_data_b.push_back(mem_wdata_b);
            end
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic start_load(input logic b, input logic [31:0] base);
        cap_addr_a.delete(); cap_data_a.delete();
        cap_addr_b.delete(); cap_data_b.delete();
        done_cnt_a = 0;
        done_cnt_b = 0;
        use_b = b;
        @(posedge clk); #1;
        base_addr = base;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drive(input ins_op_t op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] addr, input logic last);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_addr = addr; in_last = last;
        if (use_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (use_b ? in_ready_b : in_ready_a) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        checks++;
        if (!ok) $display("FAIL %s accept: in_ready=0 after 50 cycles, required 1", name);
        else passes++;
    endtask

    task automatic send(input string name, input ins_op_t op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] addr, input logic last);
        drive(op, rs, rt, rd, sh, imm, addr, last);
        wait_accept(name);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((use_b ? st_b : st_a) == 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("FAIL %s idle: load did not complete within 100 cycles", name);
        else passes++;
    endtask

    // Tests
    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready_a, mem_wr_a, mem_addr_a, mem_wdata_a, count_a, done_a, err_a, ovf_a, st_a} !== '0)
            $display("FAIL reset_a: rdy=%b wr=%b addr=%h data=%h cnt=%0d done=%b err=%b ovf=%b st=%0d, required all 0",
                     in_ready_a, mem_wr_a, mem_addr_a, mem_wdata_a, count_a, done_a, err_a, ovf_a, st_a);
        else passes++;
        checks++;
        if ({in_ready_b, mem_wr_b, mem_addr_b, mem_wdata_b, count_b, done_b, err_b, ovf_b, st_b} !== '0)
            $display("FAIL reset_b: rdy=%b wr=%b addr=%h data=%h cnt=%0d st=%0d, required all 0",
                     in_ready_b, mem_wr_b, mem_addr_b, mem_wdata_b, count_b, st_b);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        // in_valid outside RUN must be ignored
        in_valid_a = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b0) $display("FAIL idle_ready: in_ready=%b, required 0", in_ready_a);
        else passes++;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic test_rtype();
        mem_ready = 1'b1;
        start_load(1'b0, 32'h0000_0100);
        send("rtype_add", INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        send("rtype_sll", INS_SLL, 5'd0, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0, 1'b1);
        wait_idle("rtype");
        checks++;
        if (cap_addr_a.size() != 2 || cap_addr_a[0] !== 32'h100 || cap_data_a[0] !== 32'h0022_1820 ||
            cap_addr_a[1] !== 32'h104 || cap_data_a[1] !== 32'h0005_2080)
            $display("FAIL rtype_words: got %0d writes (%h@%h, %h@%h), required 00221820@100, 00052080@104",
                     cap_addr_a.size(), cap_data_a[0], cap_addr_a[0], cap_data_a[1], cap_addr_a[1]);
        else passes++;
        checks++;
        if (count_a !== 11'd2) $display("FAIL rtype_count: count=%0d, required 2", count_a);
        else passes++;
        checks++;
        if (done_cnt_a != 1) $display("FAIL rtype_done: done pulses=%0d, required 1", done_cnt_a);
        else passes++;
    endtask

    task automatic test_itype_jtype();
        logic [31:0] ea[4];
        logic [31:0] ed[4];
        ea = '{32'h400, 32'h404, 32'h408, 32'h40C};
        ed = '{32'h2008_0005, 32'h3C01_1234, 32'hAFA2_0004, 32'h0810_0000};
        mem_ready = 1'b1;
        start_load(1'b0, 32'h0000_0403);
        send("addi", INS_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
        send("lui", INS_LUI, 5'd7, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
        send("sw", INS_SW, 5'd29, 5'd2, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
        send("j", INS_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000, 1'b1);
        wait_idle("ij");
        checks++;
        if (cap_addr_a.size() != 4) $display("FAIL ij_count: writes=%0d, required 4", cap_addr_a.size());
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= cap_addr_a.size() || cap_addr_a[i] !== ea[i] || cap_data_a[i] !== ed[i])
                $display("FAIL ij_word%0d: got %h@%h, required %h@%h", i, cap_data_a[i], cap_addr_a[i], ed[i], ea[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back_stall();
        mem_ready = 1'b0;
        start_load(1'b0, 32'h0000_0500);
        send("stall_first", INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive(INS_ADD, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready_a !== 1'b0 || mem_wr_a !== 1'b1 || mem_wdata_a !== 32'h0022_1820 || mem_addr_a !== 32'h500)
                $display("FAIL stall_hold%0d: rdy=%b wr=%b data=%h addr=%h, required 0 1 00221820 00000500",
                         i, in_ready_a, mem_wr_a, mem_wdata_a, mem_addr_a);
            else passes++;
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        wait_accept("stall_second");
        wait_idle("stall");
        checks++;
        if (cap_addr_a.size() != 2 || cap_addr_a[0] !== 32'h500 || cap_data_a[0] !== 32'h0022_1820 ||
            cap_addr_a[1] !== 32'h504 || cap_data_a[1] !== 32'h0085_3020)
            $display("FAIL stall_words: got %0d writes (%h@%h, %h@%h), required 00221820@500, 00853020@504",
                     cap_addr_a.size(), cap_data_a[0], cap_addr_a[0], cap_data_a[1], cap_addr_a[1]);
        else passes++;
    endtask

    task automatic test_illegal();
        mem_ready = 1'b1;
        start_load(1'b0, 32'h0000_0200);
        send("ill_add1", INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        send("ill_none", INS_NONE, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
        send("ill_add2", INS_ADD, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_idle("ill");
        checks++;
        if (cap_addr_a.size() != 2 || cap_addr_a[0] !== 32'h200 || cap_data_a[0] !== 32'h0022_1820 ||
            cap_addr_a[1] !== 32'h204 || cap_data_a[1] !== 32'h0085_3020)
            $display("FAIL ill_words: got %0d writes (%h@%h, %h@%h), required 00221820@200, 00853020@204",
                     cap_addr_a.size(), cap_data_a[0], cap_addr_a[0], cap_data_a[1], cap_addr_a[1]);
        else passes++;
        checks++;
        if (err_a !== 1'b1 || count_a !== 11'd2 || ovf_a !== 1'b0)
            $display("FAIL ill_flags: err=%b count=%0d ovf=%b, required err=1 count=2 ovf=0", err_a, count_a, ovf_a);
        else passes++;

        // Out-of-enum code as the only, final descriptor
        start_load(1'b0, 32'h0000_0240);
        checks++;
        if (err_a !== 1'b0) $display("FAIL err_clear: err=%b after start, required 0", err_a);
        else passes++;
        send("ill_code30", ins_op_t'(5'd30), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_idle("ill30");
        checks++;
        if (cap_addr_a.size() != 0 || err_a !== 1'b1 || count_a !== 11'd0 || done_cnt_a != 1)
            $display("FAIL ill30: writes=%0d err=%b count=%0d done=%0d, required 0 1 0 1",
                     cap_addr_a.size(), err_a, count_a, done_cnt_a);
        else passes++;
    endtask

    task automatic test_overflow();
        mem_ready = 1'b1;
        start_load(1'b1, 32'h0000_0300);
        send("ovf_1", INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        send("ovf_2", INS_ADD, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
        send("ovf_3", INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_idle("ovf");
        checks++;
        if (cap_addr_b.size() != 2 || cap_addr_b[0] !== 32'h300 || cap_data_b[0] !== 32'h0022_1820 ||
            cap_addr_b[1] !== 32'h304 || cap_data_b[1] !== 32'h0085_3020)
            $display("FAIL ovf_words: got %0d writes (%h@%h, %h@%h), required 00221820@300, 00853020@304",
                     cap_addr_b.size(), cap_data_b[0], cap_addr_b[0], cap_data_b[1], cap_addr_b[1]);
        else passes++;
        checks++;
        if (ovf_b !== 1'b1 || count_b !== 2'd2 || err_b !== 1'b0 || done_cnt_b != 1)
            $display("FAIL ovf_flags: ovf=%b count=%0d err=%b done=%0d, required 1 2 0 1",
                     ovf_b, count_b, err_b, done_cnt_b);
        else passes++;
    endtask

    task automatic test_wrap();
        mem_ready = 1'b1;
        start_load(1'b0, 32'hFFFF_FFFC);
        send("wrap_1", INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        send("wrap_2", INS_ADD, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_idle("wrap");
        checks++;
        if (cap_addr_a.size() != 2 || cap_addr_a[0] !== 32'hFFFF_FFFC || cap_addr_a[1] !== 32'h0)
            $display("FAIL wrap_addr: got %0d writes (@%h, @%h), required @fffffffc, @00000000",
                     cap_addr_a.size(), cap_addr_a[0], cap_addr_a[1]);
        else passes++;
    endtask

    task automatic test_reset_midop();
        mem_ready = 1'b0;
        start_load(1'b0, 32'h0000_0600);
        send("rst_add", INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        checks++;
        if (mem_wr_a !== 1'b1) $display("FAIL rst_pre: mem_wr=%b, required 1", mem_wr_a);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready_a, mem_wr_a, mem_addr_a, mem_wdata_a, count_a, done_a, err_a, ovf_a, st_a} !== '0)
            $display("FAIL rst_midop: rdy=%b wr=%b addr=%h data=%h cnt=%0d st=%0d, required all 0",
                     in_ready_a, mem_wr_a, mem_addr_a, mem_wdata_a, count_a, st_a);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (cap_addr_a.size() != 0 || mem_wr_a !== 1'b0)
            $display("FAIL rst_discard: writes=%0d mem_wr=%b, required 0 0", cap_addr_a.size(), mem_wr_a);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        done_cnt_a = 0;
        done_cnt_b = 0;
        use_b = 1'b0;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        base_addr = 32'h0;
        in_op = INS_NONE;
        in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
        in_imm = 16'h0; in_addr = 26'h0; in_last = 1'b0;
        mem_ready = 1'b1;

        test_reset();
        test_rtype();
        test_itype_jtype();
        test_back_to_back_stall();
        test_illegal();
        test_overflow();
        test_wrap();
        test_reset_midop();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ins_encoder.md
INS_ENCODER -- requirements
Module: ins_encoder

Interface
REQ-001 Parameter DEPTH, default 1024: maximum instruction words written per program load.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  pulse in IDLE that begins a load; ignored in any other state.
REQ-006 base_addr  in  32  byte address of the first word; bits [1:0] are ignored.
REQ-007 in_valid  in  1  an instruction descriptor is presented.
REQ-008 in_ready  out  1  the descriptor is accepted when in_valid && in_ready.
REQ-009 in_op  in  ins_op_t  mnemonic to encode.
REQ-010 in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
REQ-011 in_imm  in  16  immediate; in_addr  in  26  jump target; in_last  in  1  marks the final descriptor.
REQ-012 mem_wr  out  1  a write is pending; mem_ready  in  1  the write is consumed when mem_wr && mem_ready.
REQ-013 mem_addr  out  32  word-aligned write address; mem_wdata  out  32  encoded instruction.
REQ-014 count  out  $clog2(DEPTH+1)  number of words written; done  out  1  one-cycle completion pulse; err  out  1  sticky illegal-op flag; ovf  out  1  sticky overflow flag.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN and FIN.
- IDLE -> RUN on start: the write pointer loads {base_addr[31:2],2'b00}; count, err and ovf clear.
- RUN -> DRAIN on an accepted descriptor with in_last=1.
- DRAIN -> FIN once no write is pending.
- FIN -> IDLE unconditionally; done=1 for that single cycle.
REQ-016 in_ready SHALL be 1 only in RUN, and only while (!mem_wr || mem_ready): a one-deep output register that is skid-free and allows full throughput.
REQ-017 Latency: the word for a descriptor accepted at edge N SHALL drive mem_wdata/mem_addr with mem_wr=1 from edge N until the edge at which it is consumed; mem_wdata/mem_addr SHALL stay stable while mem_wr && !mem_ready.
REQ-018 R-type encoding SHALL be {OP_RTYPE, rs, rt, rd, shamt, FUNC_x}.
- shamt is forced to 0 except for SLL/SRL/SRA.
- rs is forced to 0 for SLL/SRL/SRA.
- rt, rd and shamt are forced to 0 for JR.
REQ-019 I-type encoding SHALL be {OP_x, rs, rt, imm} for ADDI, ADDIU, ORI, XORI, LUI, LW, SW, BEQ, BNE, SLTI and SLTIU; rs is forced to 0 for LUI.
REQ-020 J-type encoding SHALL be {OP_J or OP_JAL, addr}.
REQ-021 Illegal op (INS_NONE or any value outside the enum):
- the descriptor is accepted and no word is written;
- err is set;
- the pointer and count are unchanged;
- if in_last=1, the normal DRAIN transition still occurs.
REQ-022 Each valid word SHALL advance the pointer by 4 (modulo 2^32, so 0xFFFFFFFC wraps to 0x0) and increment count.
REQ-023 With count==DEPTH, further valid descriptors SHALL be accepted and dropped, with ovf set; count saturates at DEPTH.
REQ-024 When an illegal op coincides with overflow, both err and ovf SHALL be set.
REQ-025 A start pulse in RUN, DRAIN or FIN SHALL be ignored; in_valid in IDLE SHALL be ignored (in_ready=0).

Reset
REQ-026 rst asserted at any time SHALL force state=IDLE; mem_wr=0; mem_addr=0; mem_wdata=0; count=0; done=0; err=0; ovf=0; in_ready=0.
REQ-027 A pending write that is aborted by reset mid-operation SHALL be discarded and not reissued.

Structure
REQ-028 ins_op_t (INS_NONE plus one entry per supported mnemonic) SHALL be added to the shared MIPS_DEF package; the encoder SHALL reuse the existing OP_* and FUNC_* constants from that package.
REQ-029 The combinational field packing SHALL be a sub-module, ins_pack, with inputs op and fields, and outputs word[31:0] and illegal; ins_encoder holds the FSM, output register, pointer and counters.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- start, base_addr=0x100; ADD rs=1 rt=2 rd=3, then SLL rt=5 rd=4 shamt=2 with in_last, mem_ready=1 -> writes 0x00221820@0x100 and 0x00052080@0x104, count=2, done pulses once.
- ADDI rs=0 rt=8 imm=5; LUI rs=7 rt=1 imm=0x1234; SW rs=29 rt=2 imm=4; J addr=0x0100000 -> 0x20080005, 0x3C011234, 0xAFA20004, 0x08100000.
- mem_ready held 0 for 3 cycles on the first word -> in_ready=0 and mem_wdata/mem_addr stable; resumes with no loss or duplication.
- INS_NONE between two ADDs -> two writes at consecutive addresses, err=1, count=2.
- DEPTH=2, three ADDs -> two writes, ovf=1, count=2.
- base_addr=0xFFFFFFFC, two ADDs -> addresses 0xFFFFFFFC then 0x0.
- rst asserted while mem_wr=1 -> all outputs at reset values the same cycle.
